// File: rtl/fir_coef_loader.sv
// -----------------------------------------------------------------------------
// fir_coef_loader
//   Writer end of the FIR tap-chain coefficient interface. Collects one set of
//   coefficient words from a host valid/ready stream into a local buffer, then
//   shifts the set into the systolic tap chain, highest tap first, so that
//   coef[0] ends up in tap 0.
//
// Configuration macro:
//   FIR_COEF_SYM_EN  symmetric-filter mode. The host sends only
//                    ceil(NUM_TAPS/2) words; the shift still emits NUM_TAPS
//                    words, mirroring the buffer around the centre tap.
//                    Undefined (default): the host sends all NUM_TAPS words.
//
// Parameters:
//   H_N_WIDTH     coefficient width (signed), must match the tap chain
//   NUM_TAPS      taps in the chain (>= 2)
//
// Ports:
//   clk           clock, all logic on posedge
//   rst_n         asynchronous active-low reset
//   coef_in       coefficient word from host (signed)
//   coef_in_vld   coef_in valid
//   coef_in_last  final word of a set, qualified by vld & rdy
//   coef_in_rdy   loader can accept a word
//   h_n_out       coefficient to tap 0 h_n_in (registered)
//   h_n_out_vld   shift strobe to tap 0 h_n_in_vld (registered)
//   busy          collecting or shifting a set
//   done          1-cycle pulse, chain fully loaded
//   err           1-cycle pulse, malformed set discarded
// -----------------------------------------------------------------------------
module fir_coef_loader #(
   parameter int unsigned H_N_WIDTH = 18,
   parameter int unsigned NUM_TAPS  = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic signed [H_N_WIDTH-1:0] coef_in,
   input  logic                        coef_in_vld,
   input  logic                        coef_in_last,
   output logic                        coef_in_rdy,
   output logic signed [H_N_WIDTH-1:0] h_n_out,
   output logic                        h_n_out_vld,
   output logic                        busy,
   output logic                        done,
   output logic                        err
);

`ifdef FIR_COEF_SYM_EN
   localparam int unsigned N_WORDS = (NUM_TAPS + 1) / 2;
`else
   localparam int unsigned N_WORDS = NUM_TAPS;
`endif
   localparam int unsigned IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
   localparam int unsigned CNT_W = $clog2(N_WORDS + 1);
   localparam int unsigned TAP_W = $clog2(NUM_TAPS);

   typedef enum logic [1:0] {StIdle, StCollect, StShift, StErr} state_e;

   // Buffer slot holding the coefficient destined for a given tap.
   function automatic logic [IDX_W-1:0] buf_idx(input logic [TAP_W-1:0] tap);
      int unsigned t;
      t = 32'(tap);
`ifdef FIR_COEF_SYM_EN
      if (t >= N_WORDS) t = NUM_TAPS - 1 - t;
`endif
      return IDX_W'(t);
   endfunction

   state_e                      state_q, state_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [TAP_W-1:0]            tap_q, tap_d;
   logic                        rdy_q, rdy_d;
   logic signed [H_N_WIDTH-1:0] h_n_out_q, h_n_out_d;
   logic                        vld_q, vld_d;
   logic                        done_q, done_d;
   logic                        err_q, err_d;

   logic signed [H_N_WIDTH-1:0] coef_buf [N_WORDS];
   logic                        accept;
   logic                        wr_en;
   logic [IDX_W-1:0]            wr_idx;
   logic [CNT_W-1:0]            cnt_inc;
   logic [IDX_W-1:0]            first_idx;
   logic signed [H_N_WIDTH-1:0] first_word;

   assign accept    = coef_in_vld & rdy_q;
   assign cnt_inc   = cnt_q + CNT_W'(1);
   assign wr_idx    = IDX_W'(cnt_q);
   assign first_idx = buf_idx(TAP_W'(NUM_TAPS - 1));
   // The first emitted word may be the one being written on this very edge.
   assign first_word = (first_idx == wr_idx) ? coef_in : coef_buf[first_idx];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tap_d     = tap_q;
      h_n_out_d = h_n_out_q;
      vld_d     = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      wr_en     = 1'b0;
      unique case (state_q)
         StIdle, StCollect: begin
            if (accept) begin
               wr_en = 1'b1;
               if (coef_in_last && (cnt_inc == CNT_W'(N_WORDS))) begin
                  state_d   = StShift;
                  cnt_d     = '0;
                  tap_d     = TAP_W'(NUM_TAPS - 1);
                  h_n_out_d = first_word;
                  vld_d     = 1'b1;
               end else if (coef_in_last || (cnt_inc == CNT_W'(N_WORDS))) begin
                  state_d = StErr;
                  cnt_d   = '0;
                  err_d   = 1'b1;
               end else begin
                  state_d = StCollect;
                  cnt_d   = cnt_inc;
               end
            end
         end
         StShift: begin
            // tap_q is the tap whose word is currently on h_n_out.
            if (tap_q == '0) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end else begin
               tap_d     = tap_q - TAP_W'(1);
               h_n_out_d = coef_buf[buf_idx(tap_q - TAP_W'(1))];
               vld_d     = 1'b1;
            end
         end
         StErr: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      rdy_d = (state_d == StIdle) || (state_d == StCollect);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         tap_q     <= '0;
         rdy_q     <= 1'b0;
         h_n_out_q <= '0;
         vld_q     <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tap_q     <= tap_d;
         rdy_q     <= rdy_d;
         h_n_out_q <= h_n_out_d;
         vld_q     <= vld_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // Buffer contents are only meaningful once a full set is collected.
   always_ff @(posedge clk) begin
      if (wr_en) coef_buf[wr_idx] <= coef_in;
   end

   assign coef_in_rdy = rdy_q;
   assign h_n_out     = h_n_out_q;
   assign h_n_out_vld = vld_q;
   assign done        = done_q;
   assign err         = err_q;
   assign busy        = (state_q == StCollect) || (state_q == StShift);

endmodule
